// File: rtl/dcache_wb_bridge.sv
// Bridges the data cache memory command/response bus onto a Wishbone B4 master.
// Single-beat writes, incrementing read bursts, and a per-beat watchdog that forces error completion.
module dcache_wb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned AdrW  = 30,
    localparam int unsigned DataW = 32,
    localparam int unsigned SelW  = 4,
    localparam int unsigned LenW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_mem_cmd_valid,
    output logic             io_mem_cmd_ready,
    input  logic             io_mem_cmd_payload_wr,
    input  logic [31:0]      io_mem_cmd_payload_address,
    input  logic [DataW-1:0] io_mem_cmd_payload_data,
    input  logic [SelW-1:0]  io_mem_cmd_payload_mask,
    input  logic [LenW-1:0]  io_mem_cmd_payload_length,
    input  logic             io_mem_cmd_payload_last,
    output logic             io_mem_rsp_valid,
    output logic [DataW-1:0] io_mem_rsp_payload_data,
    output logic             io_mem_rsp_payload_error,
    output logic             wb_cyc,
    output logic             wb_stb,
    output logic             wb_we,
    output logic [AdrW-1:0]  wb_adr,
    output logic [DataW-1:0] wb_dat_w,
    output logic [SelW-1:0]  wb_sel,
    output logic [2:0]       wb_cti,
    output logic [1:0]       wb_bte,
    input  logic [DataW-1:0] wb_dat_r,
    input  logic             wb_ack,
    input  logic             wb_err,
    output logic             wr_error
);
    localparam int unsigned WdW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned WdMax = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [2:0]  CtiInc = 3'b010;
    localparam logic [2:0]  CtiEnd = 3'b111;

    typedef enum logic [1:0] {IDLE, READ, WRITE} stateE;

    stateE           state;
    logic [LenW-1:0] beatsLeft;
    logic [WdW-1:0]  wdCount;
    logic            wdTimeout_c;
    logic            beatEnd_c;
    logic            beatErr_c;
    logic            unusedBits;

    // Watchdog fires only when the slave stays silent for the whole allowance.
    assign wdTimeout_c = (TIMEOUT_CYCLES != 0) && (wdCount == WdW'(WdMax)) && !wb_ack && !wb_err;
    assign beatEnd_c   = wb_ack || wb_err || wdTimeout_c;
    assign beatErr_c   = wb_err || wdTimeout_c;
    assign wb_bte      = 2'b00;
    assign unusedBits  = ^{io_mem_cmd_payload_last, io_mem_cmd_payload_address[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                    <= IDLE;
            io_mem_cmd_ready         <= 1'b0;
            wb_cyc                   <= 1'b0;
            wb_stb                   <= 1'b0;
            wb_we                    <= 1'b0;
            wb_adr                   <= '0;
            wb_dat_w                 <= '0;
            wb_sel                   <= '0;
            wb_cti                   <= '0;
            beatsLeft                <= '0;
            wdCount                  <= '0;
            io_mem_rsp_valid         <= 1'b0;
            io_mem_rsp_payload_data  <= '0;
            io_mem_rsp_payload_error <= 1'b0;
            wr_error                 <= 1'b0;
        end else begin
            io_mem_rsp_valid <= 1'b0;
            wr_error         <= 1'b0;
            unique case (state)
                IDLE: begin
                    io_mem_cmd_ready <= 1'b1;
                    if (io_mem_cmd_valid && io_mem_cmd_ready) begin
                        io_mem_cmd_ready <= 1'b0;
                        wb_cyc           <= 1'b1;
                        wb_stb           <= 1'b1;
                        wb_adr           <= io_mem_cmd_payload_address[31:2];
                        wdCount          <= '0;
                        if (io_mem_cmd_payload_wr) begin
                            wb_we    <= 1'b1;
                            wb_dat_w <= io_mem_cmd_payload_data;
                            wb_sel   <= io_mem_cmd_payload_mask;
                            wb_cti   <= CtiEnd;
                            state    <= WRITE;
                        end else begin
                            wb_we     <= 1'b0;
                            wb_sel    <= '1;
                            wb_cti    <= (io_mem_cmd_payload_length != '0) ? CtiInc : CtiEnd;
                            beatsLeft <= io_mem_cmd_payload_length;
                            state     <= READ;
                        end
                    end
                end
                READ: begin
                    // Every beat returns a word, even on error, so the cache word count stays aligned.
                    if (beatEnd_c) begin
                        io_mem_rsp_valid         <= 1'b1;
                        io_mem_rsp_payload_data  <= wdTimeout_c ? '0 : wb_dat_r;
                        io_mem_rsp_payload_error <= beatErr_c;
                        wdCount                  <= '0;
                        if (beatsLeft == '0) begin
                            wb_cyc           <= 1'b0;
                            wb_stb           <= 1'b0;
                            io_mem_cmd_ready <= 1'b1;
                            state            <= IDLE;
                        end else begin
                            wb_adr    <= wb_adr + AdrW'(1);
                            beatsLeft <= beatsLeft - LenW'(1);
                            wb_cti    <= (beatsLeft == LenW'(1)) ? CtiEnd : CtiInc;
                        end
                    end else begin
                        wdCount <= wdCount + WdW'(1);
                    end
                end
                WRITE: begin
                    if (beatEnd_c) begin
                        wr_error         <= beatErr_c;
                        wb_cyc           <= 1'b0;
                        wb_stb           <= 1'b0;
                        wb_we            <= 1'b0;
                        io_mem_cmd_ready <= 1'b1;
                        state            <= IDLE;
                    end else begin
                        wdCount <= wdCount + WdW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_wb_bridge.sv
// Self-checking bench for dcache_wb_bridge: table vectors, random transfers against
// a transaction-level model, and hand sequences for watchdog and mid-burst reset.
module tb_dcache_wb_bridge;
    localparam int unsigned Timeout = 16;

    logic        clk;
    logic        reset;
    logic        io_mem_cmd_valid;
    logic        io_mem_cmd_ready;
    logic        io_mem_cmd_payload_wr;
    logic [31:0] io_mem_cmd_payload_address;
    logic [31:0] io_mem_cmd_payload_data;
    logic [3:0]  io_mem_cmd_payload_mask;
    logic [2:0]  io_mem_cmd_payload_length;
    logic        io_mem_cmd_payload_last;
    logic        io_mem_rsp_valid;
    logic [31:0] io_mem_rsp_payload_data;
    logic        io_mem_rsp_payload_error;
    logic        wb_cyc, wb_stb, wb_we;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_r;
    logic        wb_ack, wb_err;
    logic        wr_error;

    dcache_wb_bridge #(.TIMEOUT_CYCLES(Timeout)) dut (
        .clk(clk), .reset(reset),
        .io_mem_cmd_valid(io_mem_cmd_valid), .io_mem_cmd_ready(io_mem_cmd_ready),
        .io_mem_cmd_payload_wr(io_mem_cmd_payload_wr),
        .io_mem_cmd_payload_address(io_mem_cmd_payload_address),
        .io_mem_cmd_payload_data(io_mem_cmd_payload_data),
        .io_mem_cmd_payload_mask(io_mem_cmd_payload_mask),
        .io_mem_cmd_payload_length(io_mem_cmd_payload_length),
        .io_mem_cmd_payload_last(io_mem_cmd_payload_last),
        .io_mem_rsp_valid(io_mem_rsp_valid),
        .io_mem_rsp_payload_data(io_mem_rsp_payload_data),
        .io_mem_rsp_payload_error(io_mem_rsp_payload_error),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_bte(wb_bte),
        .wb_dat_r(wb_dat_r), .wb_ack(wb_ack), .wb_err(wb_err), .wr_error(wr_error)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [2:0]  len;
        int          errBeat;
        int          maxWait;
        logic [31:0] salt;
        int          expRsp;
        int          expErrRsp;
        int          expWrErr;
        int          expCyc;
    } vecT;

    typedef struct packed {
        logic        we;
        logic [29:0] adr;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [31:0] datW;
    } beatT;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rspT;

    beatT        expBeatQ[$];
    rspT         expRspQ[$];
    int          checks = 0;
    int          errors = 0;
    int          rspCount, errRspCount, wrErrCount, cycCount;
    int          errBeat = -1;
    int          maxWait = 0;
    logic [31:0] salt = '0;
    bit          silent = 0;
    bit          cycChkEn = 0;
    bit          prevTerm = 0, prevWe = 0, prevErr = 0;
    int          beatIdx = 0, waitCnt = 0, curWait = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a read of L+1 beats walks word addresses modulo 2^30; memory word = address ^ salt.
    task automatic modelPush(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] mask, input logic [2:0] len, input int errBt,
                             input logic [31:0] sl);
        logic [29:0] base;
        logic [29:0] a;
        base = addr[31:2];
        if (wr) begin
            expBeatQ.push_back('{1'b1, base, mask, 3'b111, data});
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                a = base + 30'(i);
                expBeatQ.push_back('{1'b0, a, 4'hF, (i == int'(len)) ? 3'b111 : 3'b010, 32'h0});
                expRspQ.push_back('{{2'b00, a} ^ sl, (i == errBt)});
            end
        end
    endtask

    // Wishbone slave plus response monitor, all sampled mid-cycle.
    always @(negedge clk) begin : slaveMon
        rspT  e;
        beatT b;
        bit   errNow;
        if (io_mem_rsp_valid) begin
            rspCount++;
            if (io_mem_rsp_payload_error) errRspCount++;
            if (expRspQ.size() == 0) begin
                chk("rsp_unexpected", io_mem_rsp_valid, 1'b0);
            end else begin
                e = expRspQ.pop_front();
                chk("rsp_data", io_mem_rsp_payload_data, e.data);
                chk("rsp_error", io_mem_rsp_payload_error, e.err);
            end
        end
        if (wr_error) wrErrCount++;
        if (cycChkEn) begin
            chk("rsp_timing", io_mem_rsp_valid, prevTerm && !prevWe);
            chk("wr_error_timing", wr_error, prevTerm && prevWe && prevErr);
        end
        if (wb_cyc) cycCount++;
        prevTerm = 0;
        if (wb_cyc && wb_stb && !silent) begin
            if (waitCnt >= curWait) begin
                if (expBeatQ.size() == 0) begin
                    chk("beat_unexpected", wb_stb, 1'b0);
                end else begin
                    b = expBeatQ.pop_front();
                    chk("beat_ctl", {wb_we, wb_adr, wb_sel, wb_cti, wb_bte},
                        {b.we, b.adr, b.sel, b.cti, 2'b00});
                    if (b.we) chk("beat_dat_w", wb_dat_w, b.datW);
                end
                errNow   = (beatIdx == errBeat);
                wb_err   = errNow;
                wb_ack   = errNow ? 1'($urandom_range(0, 1)) : 1'b1;
                wb_dat_r = {2'b00, wb_adr} ^ salt;
                prevTerm = 1;
                prevWe   = wb_we;
                prevErr  = errNow;
                beatIdx++;
                waitCnt  = 0;
                curWait  = $urandom_range(0, maxWait);
            end else begin
                wb_ack   = 1'b0;
                wb_err   = 1'b0;
                wb_dat_r = $urandom();
                waitCnt++;
            end
        end else begin
            wb_ack = 1'b0;
            wb_err = 1'b0;
            if (!wb_cyc) begin
                beatIdx = 0;
                waitCnt = 0;
                curWait = $urandom_range(0, maxWait);
            end
        end
    end

    task automatic issueOnly(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] mask, input logic [2:0] len);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!io_mem_cmd_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_ready_before_issue", io_mem_cmd_ready, 1'b1);
        io_mem_cmd_valid           = 1'b1;
        io_mem_cmd_payload_wr      = wr;
        io_mem_cmd_payload_address = addr;
        io_mem_cmd_payload_data    = data;
        io_mem_cmd_payload_mask    = mask;
        io_mem_cmd_payload_length  = wr ? 3'($urandom()) : len;
        io_mem_cmd_payload_last    = 1'($urandom());
        @(posedge clk);
        #1;
        io_mem_cmd_valid           = 1'b0;
        io_mem_cmd_payload_address = $urandom();
        io_mem_cmd_payload_data    = $urandom();
    endtask

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic [2:0] len, output int lat);
        issueOnly(wr, addr, data, mask, len);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("bus_start", {wb_cyc, wb_stb, io_mem_cmd_ready}, 3'b110);
        end while (!io_mem_cmd_ready && lat < 500);
        #1;
        chk("cmd_ready_return", io_mem_cmd_ready, 1'b1);
        chk("idle_gap", wb_cyc, 1'b0);
    endtask

    task automatic runVec(input vecT v, input string tag);
        int lat;
        errBeat = v.errBeat;
        maxWait = v.maxWait;
        salt    = v.salt;
        rspCount = 0; errRspCount = 0; wrErrCount = 0; cycCount = 0;
        modelPush(v.wr, v.addr, v.data, v.mask, v.len, v.errBeat, v.salt);
        issue(v.wr, v.addr, v.data, v.mask, v.len, lat);
        chk({tag, "_rsp_count"}, 96'(rspCount), 96'(v.expRsp));
        chk({tag, "_err_rsp_count"}, 96'(errRspCount), 96'(v.expErrRsp));
        chk({tag, "_wr_error_count"}, 96'(wrErrCount), 96'(v.expWrErr));
        if (v.expCyc >= 0) begin
            chk({tag, "_cyc_cycles"}, 96'(cycCount), 96'(v.expCyc));
            chk({tag, "_ready_latency"}, 96'(lat), 96'(v.expCyc + 1));
        end
        chk({tag, "_queues_drained"}, 96'(expRspQ.size() + expBeatQ.size()), 96'(0));
    endtask

    initial begin : globalGuard
        #500us;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin : main
        vecT vecs[8];
        vecT r;
        int  lat, wrK, stbLowK, rsp1K, rsp2K, g;

        vecs[0] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 3'd7, -1, 0, 32'h0,         8, 0, 0, 8};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'h5, 3'd0, -1, 0, 32'h0,         0, 0, 0, 1};
        vecs[2] = '{1'b0, 32'h0000_2000, 32'h0,         4'h0, 3'd3,  2, 0, 32'h0,         4, 1, 0, 4};
        vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 3'd1, -1, 0, 32'h0,         2, 0, 0, 2};
        vecs[4] = '{1'b1, 32'h0000_0044, 32'h0BAD_F00D, 4'h0, 3'd0, -1, 0, 32'h0,         0, 0, 0, 1};
        vecs[5] = '{1'b1, 32'h0000_0080, 32'h1357_9BDF, 4'hF, 3'd0,  0, 0, 32'h0,         0, 0, 1, 1};
        vecs[6] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 3'd0, -1, 0, 32'hA5A5_A5A5, 1, 0, 0, 1};
        vecs[7] = '{1'b0, 32'h0000_07F0, 32'h0,         4'h0, 3'd5,  0, 3, 32'h0F0F_0000, 6, 1, 0, -1};

        reset = 1'b0;
        io_mem_cmd_valid = 1'b0;
        io_mem_cmd_payload_wr = 1'b0;
        io_mem_cmd_payload_address = '0;
        io_mem_cmd_payload_data = '0;
        io_mem_cmd_payload_mask = '0;
        io_mem_cmd_payload_length = '0;
        io_mem_cmd_payload_last = 1'b0;
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat_r = '0;

        #12;
        chk("reset_ctl", {wb_cyc, wb_stb, wb_we, io_mem_rsp_valid, io_mem_rsp_payload_error,
                          wr_error, io_mem_cmd_ready}, 7'b0);
        chk("reset_bus", {wb_adr, wb_sel, wb_cti, wb_bte}, 39'b0);
        chk("reset_data", {wb_dat_w, io_mem_rsp_payload_data}, 64'b0);
        #10 reset = 1'b1;
        #1 chk("ready_before_first_clock", io_mem_cmd_ready, 1'b0);
        @(negedge clk);
        chk("ready_after_release", io_mem_cmd_ready, 1'b1);
        cycChkEn = 1;

        for (int i = 0; i < 8; i++) runVec(vecs[i], $sformatf("vec%0d", i));

        for (int n = 0; n < 30; n++) begin
            r.wr      = 1'($urandom_range(0, 1));
            r.addr    = $urandom();
            r.data    = $urandom();
            r.mask    = 4'($urandom());
            r.len     = 3'($urandom());
            r.maxWait = $urandom_range(0, 3);
            r.salt    = $urandom();
            if (r.wr) r.errBeat = ($urandom_range(0, 3) == 0) ? 0 : -1;
            else      r.errBeat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(r.len))) : -1;
            r.expRsp    = r.wr ? 0 : int'(r.len) + 1;
            r.expErrRsp = (!r.wr && r.errBeat >= 0) ? 1 : 0;
            r.expWrErr  = (r.wr && r.errBeat == 0) ? 1 : 0;
            r.expCyc    = (r.maxWait == 0) ? (r.wr ? 1 : int'(r.len) + 1) : -1;
            runVec(r, "rnd");
        end

        // Silent slave on a write: forced error on the 16th edge after stb rose.
        silent = 1; cycChkEn = 0; wrErrCount = 0;
        issueOnly(1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, 3'd0);
        wrK = 0; stbLowK = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (wr_error && wrK == 0) wrK = k;
            if (!wb_stb && stbLowK == 0) stbLowK = k;
        end
        chk("to_wr_error_cycle", 96'(wrK), 96'(Timeout + 1));
        chk("to_stb_drop_cycle", 96'(stbLowK), 96'(Timeout + 1));
        chk("to_wr_error_pulses", 96'(wrErrCount), 96'(1));
        chk("to_ready", io_mem_cmd_ready, 1'b1);

        // Silent slave on a two-beat read: each beat times out with zero data and error.
        expRspQ.push_back('{32'h0, 1'b1});
        expRspQ.push_back('{32'h0, 1'b1});
        issueOnly(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'd1);
        rsp1K = 0; rsp2K = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (io_mem_rsp_valid) begin
                if (rsp1K == 0) rsp1K = k;
                else if (rsp2K == 0) rsp2K = k;
            end
            if (k == 20) chk("to_rd_second_adr", wb_adr, 30'h41);
        end
        chk("to_rd_rsp1_cycle", 96'(rsp1K), 96'(Timeout + 1));
        chk("to_rd_rsp2_cycle", 96'(rsp2K), 96'(2 * Timeout + 1));
        chk("to_rd_drained", 96'(expRspQ.size()), 96'(0));
        silent = 0; cycChkEn = 1;

        // Reset during the third beat of an eight-beat burst.
        errBeat = -1; maxWait = 0; salt = '0;
        modelPush(1'b0, 32'h0000_3000, 32'h0, 4'h0, 3'd7, -1, 32'h0);
        issueOnly(1'b0, 32'h0000_3000, 32'h0, 4'h0, 3'd7);
        g = 0;
        do begin
            @(negedge clk);
            #1;
            g++;
        end while (beatIdx < 3 && g < 50);
        chk("rst_beat3_adr", {wb_cyc, wb_adr}, {1'b1, 30'hC02});
        cycChkEn = 0;
        expRspQ.delete();
        expBeatQ.delete();
        #1 reset = 1'b0;
        #1 chk("rst_async_drop", {wb_cyc, wb_stb, io_mem_cmd_ready}, 3'b000);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_ctl", {wb_cyc, wb_stb, wb_we, io_mem_rsp_valid, io_mem_rsp_payload_error,
                            wr_error, io_mem_cmd_ready}, 7'b0);
        chk("rst_mid_bus", {wb_adr, wb_sel, wb_cti}, 37'b0);
        chk("rst_mid_data", {wb_dat_w, io_mem_rsp_payload_data}, 64'b0);
        #2 reset = 1'b1;
        #1 chk("rst_ready_before_clock", io_mem_cmd_ready, 1'b0);
        @(negedge clk);
        chk("rst_ready_after_release", {io_mem_cmd_ready, wb_cyc}, 2'b10);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst_no_rsp", io_mem_rsp_valid, 1'b0);
        end
        cycChkEn = 1;
        runVec(vecs[6], "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_wb_bridge.md
# dcache_wb_bridge

Converts the data cache's memory-side command/response bus into a Wishbone B4 master with registered incrementing bursts. Sits directly downstream of the data cache: accepts single-beat writes and multi-beat line-refill reads, and returns one response per read word. A watchdog ends stalled beats with an error so the cache never hangs.

## Interface
- TIMEOUT_CYCLES, 255: cycles a beat may wait for ack/err before forced error completion; 0 disables the watchdog.
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- io_mem_cmd_valid  in  1  command valid
- io_mem_cmd_ready  out  1  command accepted when valid && ready
- io_mem_cmd_payload_wr  in  1  1 = write, 0 = read
- io_mem_cmd_payload_address  in  32  byte address; bits [1:0] ignored
- io_mem_cmd_payload_data  in  32  write data
- io_mem_cmd_payload_mask  in  4  write byte enables
- io_mem_cmd_payload_length  in  3  read beats minus 1; ignored for writes
- io_mem_cmd_payload_last  in  1  ignored (writes are single-beat)
- io_mem_rsp_valid  out  1  one read word returned
- io_mem_rsp_payload_data  out  32  read word
- io_mem_rsp_payload_error  out  1  beat ended in err or timeout
- wb_cyc, wb_stb, wb_we  out  1 each  Wishbone cycle/strobe/write-enable
- wb_adr  out  30  word address
- wb_dat_w  out  32  write data
- wb_sel  out  4  byte selects
- wb_cti  out  3  010 incrementing, 111 end-of-burst
- wb_bte  out  2  constant 00 (linear)
- wb_dat_r  in  32  read data
- wb_ack, wb_err  in  1 each  beat termination
- wr_error  out  1  one-cycle pulse when a write ends in err/timeout

## Operation
- States: IDLE, READ, WRITE. io_mem_cmd_ready = (state == IDLE); no command is accepted while a transfer is in flight.
- IDLE, accept read: latch adr = address[31:2], beats_left = length, go READ. Accept write: latch adr, data, mask, go WRITE.
- READ: cyc=stb=1, we=0, sel=1111; cti=010 while beats_left != 0, 111 on the final beat. On ack or err: register rsp (valid=1, data=wb_dat_r, error=wb_err); if beats_left == 0 go IDLE (cyc/stb low next cycle), else adr += 1 (30-bit wrap, no carry out), beats_left -= 1, stb stays high.
- Errors do not abort a burst. All length+1 beats are always issued and returned because the cache counts words. An error sets rsp error only for that beat.
- WRITE: cyc=stb=we=1, cti=111, sel=mask. Mask 0000 is still issued on the bus. On ack: go IDLE. On err: pulse wr_error, go IDLE. Writes produce no io_mem_rsp.
- Watchdog: counter cleared at every beat start and on ack/err. When it reaches TIMEOUT_CYCLES with no termination, the beat completes as if err. Read: rsp error=1, data=0. Write: wr_error pulse.
- ack and err asserted together are treated as err.
- Reset (async, low): state=IDLE. cyc, stb, we, rsp_valid, rsp_error, wr_error=0. adr, dat_w, rsp data=0; sel=0; cti=000. cmd_ready is 0 while reset is low and 1 from the first clock after release. Reset mid-burst drops cyc immediately; no further responses are issued.

## Timing
- Command accepted at edge N; cyc/stb/adr valid from cycle N+1.
- Beat terminated at edge M; io_mem_rsp_valid high in cycle M+1 for exactly one cycle; next beat's adr presented in M+1.
- Zero-wait-state slave (ack in first stb cycle): a burst of L+1 beats occupies cycles N+1..N+L+1; last rsp in N+L+2; cmd_ready high again in N+L+2.
- Minimum of one idle cycle (cmd_ready=1, cyc=0) between transfers.
- Watchdog: with no ack, the forced termination edge is TIMEOUT_CYCLES cycles after stb rose.

## Test plan
- Read length=7 at 0x0000_1000, slave acks every cycle with data = adr -> 8 rsp beats with data 0x400..0x407; cti 010×7 then 111; cyc low after the 8th ack.
- Write 0xDEADBEEF, mask 0101, address 0x20 -> one cycle with we=1, sel=0101, adr=0x8, cti=111; no io_mem_rsp; cmd_ready returns after the ack.
- Read length=3, slave asserts err on beat 2 -> 4 rsp beats, error=1 only on the third; burst completes.
- Write with slave silent, TIMEOUT_CYCLES=16 -> wr_error pulse 16 cycles after stb rose; state returns to IDLE.
- Read length=1 at 0xFFFF_FFFC -> second beat adr wraps to 0x0000_0000.
- Reset asserted during beat 3 of an 8-beat read -> cyc/stb fall asynchronously; no rsp_valid afterward; cmd_ready=1 on the first clock after release.
